// File: rtl/adc_capture_ctrl.sv
// Pre-trigger ring-buffer capture sequencer driving the write port of the display capture RAM.
// Define CAP_AUTO_EN to add a forced trigger after AUTO_TIMEOUT cycles in WAIT_TRIG.
module adc_capture_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int PRE_DEPTH = 256,
  parameter int HOLDOFF   = 6000000
`ifdef CAP_AUTO_EN
  ,
  parameter int AUTO_TIMEOUT = 2000000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] ad_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              disp_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] start_addr,
  output logic              buf_ready,
  output logic              trig_seen,
  output logic [2:0]        cap_state
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_DEPTH - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_DEPTH);
  localparam logic [ADDR_W-1:0] POST_LOAD = ADDR_W'(DEPTH - PRE_DEPTH - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HOLD_W'(HOLDOFF - 1) : '0;

  logic [2:0]        state;
  logic [DATA_W-1:0] d0, d1;
  logic [ADDR_W-1:0] pre_cnt, post_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              edge_valid;
  logic              rise_hit, fall_hit, real_trig, forced, trig_fire;

  assign rise_hit  = (d1 < trig_level) && (d0 >= trig_level);
  assign fall_hit  = (d1 > trig_level) && (d0 <= trig_level);
  // edge_valid masks the first WAIT_TRIG cycle, where d1 may predate the capture run
  assign real_trig = (state == S_WAIT) && edge_valid && (trig_slope ? fall_hit : rise_hit);

`ifdef CAP_AUTO_EN
  localparam int TO_W = (AUTO_TIMEOUT > 0) ? $clog2(AUTO_TIMEOUT + 1) : 1;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= '0;
    else if (cap_en && (state == S_WAIT))
      to_cnt <= to_cnt + 1'b1;
    else
      to_cnt <= '0;
  end

  assign forced = (state == S_WAIT) && (to_cnt == TO_W'(AUTO_TIMEOUT));
`else
  assign forced = 1'b0;
`endif

  assign trig_fire = real_trig || forced;

  assign wr_en     = (state == S_ARM) || (state == S_WAIT) || (state == S_POST);
  assign wr_data   = d0;
  assign buf_ready = (state == S_DONE);
  assign cap_state = state;

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0 <= '0;
      d1 <= '0;
    end else begin
      d0 <= ad_data;
      d1 <= d0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wr_addr <= '0;
    else if (wr_en)
      wr_addr <= wr_addr + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      hold_cnt   <= '0;
      edge_valid <= 1'b0;
      start_addr <= '0;
      trig_seen  <= 1'b0;
    end else if (!cap_en) begin
      state <= S_IDLE;
    end else begin
      edge_valid <= (state == S_WAIT);
      case (state)
        S_IDLE: begin
          state   <= S_ARM;
          pre_cnt <= '0;
        end
        S_ARM: begin
          if (pre_cnt == PRE_LAST)
            state <= S_WAIT;
          else
            pre_cnt <= pre_cnt + 1'b1;
        end
        S_WAIT: begin
          if (trig_fire) begin
            start_addr <= wr_addr - PRE_OFS;
            trig_seen  <= real_trig;
            post_cnt   <= POST_LOAD;
            state      <= S_POST;
          end
        end
        S_POST: begin
          post_cnt <= post_cnt - 1'b1;
          if (post_cnt == POST_LAST)
            state <= S_DONE;
        end
        S_DONE: begin
          if (disp_done) begin
            hold_cnt <= HOLD_LOAD;
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_cnt == '0) begin
            state   <= S_ARM;
            pre_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: frame-level timeline model, trigger vector table,
// abort / async-reset / holdoff corner cases, plus a forced-trigger frame when CAP_AUTO_EN is set.
module tb_adc_capture_ctrl;

  localparam int DEPTH  = 1024;
  localparam int PRE    = 256;
  localparam int HOLD   = 10;
  localparam int POSTN  = DEPTH - PRE - 1;
  localparam int AUTO_T = 50;

  localparam int ST_IDLE = 0, ST_ARM = 1, ST_WAIT = 2, ST_POST = 3, ST_DONE = 4, ST_HOLD = 5;
  localparam int M_RAND = 0, M_UP = 1, M_DN = 2, M_STEP = 3, M_CONST = 4;

  logic       clk = 1'b0;
  logic       rst, cap_en, trig_slope, disp_done;
  logic [7:0] ad_data, trig_level, wr_data;
  logic       wr_en, buf_ready, trig_seen;
  logic [9:0] wr_addr, start_addr;
  logic [2:0] cap_state;

  adc_capture_ctrl #(
    .HOLDOFF(HOLD)
`ifdef CAP_AUTO_EN
    , .AUTO_TIMEOUT(AUTO_T)
`endif
  ) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .ad_data(ad_data),
    .trig_level(trig_level), .trig_slope(trig_slope), .disp_done(disp_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start_addr(start_addr),
    .buf_ready(buf_ready), .trig_seen(trig_seen), .cap_state(cap_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] prev;
    logic [7:0] cur;
    logic [7:0] lvl;
    logic       sl;
    logic       hit;
  } trig_vec_t;

  int         cyc, n_checks, n_fail, wr_count, last_wr_addr, model_addr, frame_wc0;
  logic [7:0] ram  [DEPTH];
  logic [7:0] samp [65536];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit trig_cond(input logic [7:0] prev, input logic [7:0] cur,
                                   input logic [7:0] lvl, input logic sl);
    return sl ? (prev > lvl && cur <= lvl) : (prev < lvl && cur >= lvl);
  endfunction

  // samp[n] is the ad_data value the DUT samples at rising edge n
  task automatic tick();
    if (cyc > 60000) begin
      $display("FAIL cycle_budget: got %0d cycles, expected under 60000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    samp[cyc + 1] = ad_data;
    @(posedge clk);
    cyc++;
    #1;
    if (wr_en === 1'b1) begin
      ram[wr_addr] = wr_data;
      wr_count++;
      last_wr_addr = int'(wr_addr);
    end
  endtask

  task automatic start_idle(output int a);
    cap_en    = 1'b1;
    frame_wc0 = wr_count;
    a         = cyc + 1;
  endtask

  // Runs one capture whose ARM phase begins at cycle a; the trigger cycle t is found by
  // scanning the sample history with the trigger rule, and everything else follows from t.
  task automatic run_frame(input int mode, input logic [7:0] lvl, input logic sl, input int a,
                           input int abort_at, output int t, output int ts);
    int base, n, exp_start, mism, budget_end;
    logic [7:0] v;
    base = model_addr;
    trig_level = lvl;
    trig_slope = sl;
    t = -1;
    ts = 1;
    budget_end = a + PRE + 3000;
    while (1) begin
      n = cyc + 1;
      case (mode)
        M_UP:    v = 8'(n % 256);
        M_DN:    v = 8'(255 - n % 256);
        M_STEP:  v = (n >= a + PRE + 1 && (base + n - a) % DEPTH == 100) ? 8'd200 : 8'd0;
        M_CONST: v = 8'd10;
        default: v = 8'($urandom_range(255));
      endcase
      ad_data   = v;
      disp_done = (n == a + 100);
      if (abort_at >= 0 && t >= 0 && n == t + abort_at + 1) cap_en = 1'b0;
      tick();
      if (t < 0 && cyc >= a + PRE + 1) begin
        if (trig_cond(samp[cyc - 1], samp[cyc], lvl, sl)) t = cyc;
`ifdef CAP_AUTO_EN
        else if (cyc == a + PRE + AUTO_T) begin
          t  = cyc;
          ts = 0;
        end
`endif
      end
      if (t >= 0 && abort_at >= 0 && cyc == t + abort_at + 1) break;
      if (t >= 0 && cyc == t + POSTN + 1) break;
      if (cyc >= budget_end) break;
    end
    disp_done = 1'b0;
    if (t < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL trigger_timeout: got no trigger by cycle %0d, expected one (level %0d)", cyc, lvl);
      return;
    end
    exp_start = ((base + t - a - PRE) % DEPTH + DEPTH) % DEPTH;
    if (abort_at >= 0) begin
      check("abort_state", cap_state, ST_IDLE);
      check("abort_wr_en", wr_en, 0);
      check("abort_buf_ready", buf_ready, 0);
      check("abort_start_addr_kept", start_addr, exp_start);
      check("abort_trig_seen_kept", trig_seen, ts);
      check("abort_writes", wr_count - frame_wc0, t + abort_at + 1 - a);
      model_addr = (base + t + abort_at + 1 - a) % DEPTH;
    end else begin
      check("frame_done_state", cap_state, ST_DONE);
      check("frame_buf_ready", buf_ready, 1);
      check("frame_wr_en_off", wr_en, 0);
      check("frame_trig_seen", trig_seen, ts);
      check("frame_start_addr", start_addr, exp_start);
      check("frame_write_count", wr_count - frame_wc0, t - a + POSTN + 1);
      check("frame_last_addr", last_wr_addr, (exp_start + DEPTH - 1) % DEPTH);
      mism = 0;
      for (int i = 0; i < DEPTH; i++)
        if (ram[(exp_start + i) % DEPTH] !== samp[t - PRE + i]) mism++;
      check("frame_contents_mismatches", mism, 0);
      model_addr = exp_start;
    end
  endtask

  // Leaves a finished frame in DONE for a while, releases it, and times the holdoff.
  task automatic release_frame(input int wait_cycles, output int a);
    int wc, hold_n;
    wc = wr_count;
    repeat (wait_cycles) tick();
    check("done_no_writes", wr_count - wc, 0);
    check("done_buf_ready", buf_ready, 1);
    check("done_state", cap_state, ST_DONE);
    disp_done = 1'b1;
    frame_wc0 = wr_count;
    tick();
    disp_done = 1'b0;
    check("hold_buf_ready_low", buf_ready, 0);
    hold_n = 0;
    while (cap_state == ST_HOLD && hold_n < 100) begin
      hold_n++;
      tick();
    end
    check("hold_cycles", hold_n, HOLD);
    check("hold_to_arm", cap_state, ST_ARM);
    a = cyc;
  endtask

  initial begin
    trig_vec_t vecs[16];
    int a, t, ts, k;

    vecs[0]  = '{8'd127, 8'd128, 8'd128, 1'b0, 1'b1};
    vecs[1]  = '{8'd127, 8'd127, 8'd128, 1'b0, 1'b0};
    vecs[2]  = '{8'd128, 8'd129, 8'd128, 1'b0, 1'b0};
    vecs[3]  = '{8'd0,   8'd255, 8'd128, 1'b0, 1'b1};
    vecs[4]  = '{8'd200, 8'd100, 8'd128, 1'b0, 1'b0};
    vecs[5]  = '{8'd129, 8'd128, 8'd128, 1'b1, 1'b1};
    vecs[6]  = '{8'd128, 8'd127, 8'd128, 1'b1, 1'b0};
    vecs[7]  = '{8'd129, 8'd129, 8'd128, 1'b1, 1'b0};
    vecs[8]  = '{8'd255, 8'd0,   8'd128, 1'b1, 1'b1};
    vecs[9]  = '{8'd100, 8'd200, 8'd128, 1'b1, 1'b0};
    vecs[10] = '{8'd0,   8'd5,   8'd0,   1'b0, 1'b0};
    vecs[11] = '{8'd255, 8'd0,   8'd255, 1'b1, 1'b0};
    vecs[12] = '{8'd254, 8'd255, 8'd255, 1'b0, 1'b1};
    vecs[13] = '{8'd1,   8'd0,   8'd0,   1'b1, 1'b1};
    vecs[14] = '{8'd10,  8'd20,  8'd15,  1'b0, 1'b1};
    vecs[15] = '{8'd20,  8'd10,  8'd15,  1'b0, 1'b0};

    rst = 1'b1; cap_en = 1'b0; ad_data = 8'hA5; trig_level = 8'd128; trig_slope = 1'b0;
    disp_done = 1'b0;
    cyc = 0; n_checks = 0; n_fail = 0; wr_count = 0; model_addr = 0; last_wr_addr = -1;
    frame_wc0 = 0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'd0;

    repeat (3) tick();
    check("reset_wr_en", wr_en, 0);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", wr_data, 0);
    check("reset_start_addr", start_addr, 0);
    check("reset_buf_ready", buf_ready, 0);
    check("reset_trig_seen", trig_seen, 0);
    check("reset_cap_state", cap_state, ST_IDLE);
    rst = 1'b0;
    tick();
    check("idle_no_write", wr_en, 0);

    // Rising ramp: trigger on 127 -> 128
    start_idle(a);
    run_frame(M_UP, 8'd128, 1'b0, a, -1, t, ts);
    if (ts) check("ramp_up_trigger_word", ram[(int'(start_addr) + PRE) % DEPTH], 128);
    release_frame(5000, a);

    // Falling descending ramp: trigger on 129 -> 128
    run_frame(M_DN, 8'd128, 1'b1, a, -1, t, ts);
    if (ts) check("ramp_dn_trigger_word", ram[(int'(start_addr) + PRE) % DEPTH], 128);
    release_frame(3, a);

    // Trigger placed at write address 100 so the frame wraps through address 0
    run_frame(M_STEP, 8'd128, 1'b0, a, -1, t, ts);
    if (ts) begin
      check("wrap_start_addr", start_addr, 868);
      check("wrap_last_post_addr", last_wr_addr, 867);
    end
    release_frame(3, a);

    for (int i = 0; i < 5; i++) begin
      run_frame(M_RAND, 8'($urandom_range(239, 16)), 1'($urandom_range(1)), a, -1, t, ts);
      release_frame(int'($urandom_range(20, 1)), a);
    end

    // cap_en dropped 100 cycles into POST
    run_frame(M_UP, 8'd128, 1'b0, a, 100, t, ts);

    // Asynchronous reset in the middle of WAIT_TRIG
    ad_data = 8'd10; trig_level = 8'd128; trig_slope = 1'b0;
    start_idle(a);
    k = 0;
    while (cap_state != ST_WAIT && k < 400) begin
      tick();
      k++;
    end
    repeat (5) tick();
    check("wait_trig_holds", cap_state, ST_WAIT);
    #2 rst = 1'b1;
    #1;
    check("async_rst_wr_en", wr_en, 0);
    check("async_rst_wr_addr", wr_addr, 0);
    check("async_rst_wr_data", wr_data, 0);
    check("async_rst_start_addr", start_addr, 0);
    check("async_rst_buf_ready", buf_ready, 0);
    check("async_rst_trig_seen", trig_seen, 0);
    check("async_rst_cap_state", cap_state, ST_IDLE);
    cap_en = 1'b0;
    tick();
    rst = 1'b0;
    model_addr = 0;
    tick();

`ifdef CAP_AUTO_EN
    // Constant input never crosses the level, so the frame must be forced
    start_idle(a);
    run_frame(M_CONST, 8'd128, 1'b0, a, -1, t, ts);
`endif

    for (int i = 0; i < 16; i++) begin
      cap_en = 1'b0;
      tick();
      ad_data = vecs[i].prev; trig_level = vecs[i].lvl; trig_slope = vecs[i].sl;
      cap_en = 1'b1;
      k = 0;
      while (cap_state != ST_WAIT && k < 400) begin
        tick();
        k++;
      end
      repeat (3) tick();
      ad_data = vecs[i].cur;
      tick();
      tick();
      check($sformatf("trig_vec_%0d", i), cap_state, vecs[i].hit ? ST_POST : ST_WAIT);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Sequences ADC sample writes into the 1024x8 dual-port capture RAM that the HDMI waveform display reads.
- Replaces free-running sample/wait sequencing with pre-trigger ring-buffer capture: level/slope trigger, post-trigger fill, frame-ready handshake to the display side, then holdoff before re-arming.
- Runs in the ADC clock domain; drives the RAM write port directly.

Parameters:
- ADDR_W, 10, RAM address width; buffer depth DEPTH = 2^ADDR_W.
- DATA_W, 8, ADC sample width.
- PRE_DEPTH, 256, samples kept before the trigger point; legal range 1..DEPTH-2.
- HOLDOFF, 6000000, clk cycles spent in HOLD after the display releases the buffer.
- AUTO_TIMEOUT, 2000000, clk cycles in WAIT_TRIG before a forced trigger (CAP_AUTO_EN only).

Ports:
- clk  in  1  ADC sample clock
- rst  in  1  asynchronous reset, active-high
- cap_en  in  1  capture enable; low aborts to IDLE
- ad_data  in  DATA_W  raw ADC sample, one per clk
- trig_level  in  DATA_W  trigger threshold
- trig_slope  in  1  0 = rising, 1 = falling
- disp_done  in  1  one-cycle pulse: display finished reading the frame
- wr_en  out  1  RAM write enable
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  DATA_W  RAM write data
- start_addr  out  ADDR_W  RAM address of the oldest sample in the frame
- buf_ready  out  1  frame complete and stable
- trig_seen  out  1  last frame was captured on a real trigger, not forced
- cap_state  out  3  current state encoding

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, start_addr=0, buf_ready=0, trig_seen=0, cap_state=IDLE. Internal sample registers d0 and d1 reset to 0. All counters reset to 0.
- Pipeline: every cycle, d0 <= ad_data and d1 <= d0. wr_data = d0, so there is 1 cycle of latency from ad_data to wr_data.
- Writes:
  - When wr_en=1, a write occurs at wr_addr.
  - wr_addr increments by 1 modulo DEPTH on the following cycle, wrapping from DEPTH-1 to 0.
  - wr_addr is never reset except by rst.
- State encoding: IDLE=0, ARM=1, WAIT_TRIG=2, POST=3, DONE=4, HOLD=5.
- IDLE:
  - wr_en=0.
  - When cap_en=1, go to ARM, clear pre_cnt and the edge-valid flag.
- ARM:
  - wr_en=1.
  - pre_cnt counts writes; after PRE_DEPTH writes, go to WAIT_TRIG.
  - Triggers are ignored in ARM.
- WAIT_TRIG:
  - wr_en=1 (the ring keeps overwriting).
  - Rising trigger: d1 < trig_level and d0 >= trig_level.
  - Falling trigger: d1 > trig_level and d0 <= trig_level.
  - Comparisons are unsigned.
  - Edge detection is suppressed on the first WAIT_TRIG cycle after ARM (d1 may be stale from IDLE).
  - On trigger, the sample d0 is written this cycle at address T = wr_addr. Latch start_addr = (T - PRE_DEPTH) mod DEPTH and set trig_seen=1. Load post_cnt = DEPTH - PRE_DEPTH - 1, then go to POST.
- POST:
  - wr_en=1, post_cnt decrements per write.
  - When post_cnt reaches 0 (the last write is at address start_addr-1 mod DEPTH), go to DONE with wr_en=0 from that next cycle.
  - A frame therefore contains exactly DEPTH samples, with the trigger sample at offset PRE_DEPTH from start_addr.
- DONE:
  - wr_en=0, buf_ready=1.
  - On disp_done, clear buf_ready, load the holdoff counter, and go to HOLD.
- HOLD:
  - wr_en=0, count HOLDOFF cycles, then go to ARM.
  - HOLDOFF=0 returns to ARM the next cycle.
- disp_done in any state other than DONE is ignored.
- cap_en=0 in any state: next cycle go to IDLE with wr_en=0 and buf_ready=0. start_addr and trig_seen keep their values. A partial frame is discarded.
- trig_level or trig_slope changes take effect on the next comparison; no resync is applied. Both inputs are quasi-static and software-driven.
- rst mid-operation: all outputs return to their reset values asynchronously.

Optional Feature:
- CAP_AUTO_EN defined:
  - WAIT_TRIG counts cycles. On reaching AUTO_TIMEOUT with no trigger, force a trigger at the current wr_addr with trig_seen=0. Otherwise behaviour is identical to a real trigger.
  - The timeout counter clears on entry to WAIT_TRIG.
  - A real trigger on the same cycle as the timeout wins, giving trig_seen=1.
- CAP_AUTO_EN undefined: WAIT_TRIG waits indefinitely and trig_seen is 1 after every frame.

Test Plan:
- Defaults, HOLDOFF=10. Reset, cap_en=1, ramp ad_data 0..255 repeating, trig_level=128, rising. Expect 256 ARM writes, then trigger where d1=127 and d0=128. start_addr=T-256 mod 1024, 767 POST writes, then buf_ready=1 and trig_seen=1.
- Same setup, falling slope, ad_data a descending ramp. Expect trigger on d1=129, d0=128, and the RAM word at start_addr+256 equal to 128.
- Wrap check: trigger at wr_addr=100. Expect start_addr=868 and the last POST write at address 867, with wr_addr wrapping from 1023 to 0 mid-frame.
- buf_ready=1 with no disp_done for 5000 cycles: wr_en stays 0, RAM unchanged. Pulse disp_done: buf_ready drops next cycle, 10 HOLD cycles follow, then ARM.
- Drop cap_en mid-POST: IDLE next cycle, wr_en=0, buf_ready=0. Assert rst mid-WAIT_TRIG: all outputs return to 0 immediately.
- CAP_AUTO_EN, AUTO_TIMEOUT=50, constant ad_data=10: forced trigger 50 cycles after WAIT_TRIG entry, trig_seen=0, frame completes with buf_ready=1.
